// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: round-robin arbiter for two writers plus an x1..x(NREG-1) clear sweep,
// driving the regfile write port through one registered stage.
module regfile_write_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_req,
  output logic            clear_busy,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_wd,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_wd,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [15:0]     stall_cnt
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);
  state_t state;
  logic   last_b;
  logic   arb_ok;
  always_comb begin
    arb_ok  = !reset && state == IDLE && !clear_req;
    a_ready = arb_ok && a_valid && (!b_valid || last_b);
    b_ready = arb_ok && b_valid && (!a_valid || !last_b);
  end
  assign clear_busy = state == CLEAR;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wd     <= '0;
      stall_cnt <= '0;
    end else if (state == IDLE) begin
      if (clear_req) begin
        state <= CLEAR;
        rf_we <= 1'b1;
        rf_rd <= AW'(1);
        rf_wd <= '0;
      end else begin
        if (a_valid && b_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        if (a_ready) begin
          last_b <= 1'b0;
          rf_rd  <= a_rd;
          rf_wd  <= a_wd;
          rf_we  <= a_rd != '0;
        end else if (b_ready) begin
          last_b <= 1'b1;
          rf_rd  <= b_rd;
          rf_wd  <= b_wd;
          rf_we  <= b_rd != '0;
        end else begin
          rf_we <= 1'b0;
        end
      end
    end else if (rf_rd == LAST_REG) begin
      state <= IDLE;
      rf_we <= 1'b0;
    end else begin
      rf_rd <= rf_rd + AW'(1);
    end
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: directed scenarios against a bench-side 32x32 regfile fed by the write port.
module tb_regfile_write_scheduler;
  logic        clk = 1'b0;
  logic        reset, clear_req, clear_busy;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, rf_rd;
  logic [31:0] a_wd, b_wd, rf_wd;
  logic        rf_we;
  logic [15:0] stall_cnt;
  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;

  regfile_write_scheduler dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_wd(b_wd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // The regfile commits one edge after the registered port; its write port is idle during system reset.
  always @(posedge clk) if (!reset && rf_we && rf_rd != 5'd0) rf[rf_rd] <= rf_wd;

  function automatic logic [31:0] rf_read(input int idx);
    return idx == 0 ? 32'd0 : rf[idx];
  endfunction

  task automatic idle_inputs;
    clear_req = 0; a_valid = 0; b_valid = 0;
    a_rd = 0; a_wd = 0; b_rd = 0; b_wd = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1; a_valid = 1; b_valid = 1; a_rd = 5'd5; b_rd = 5'd6;
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got a=%b b=%b exp 0 0", a_ready, b_ready); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== 32'd0) begin errors++; $display("FAIL reset_port got we=%b rd=%0d wd=%h exp 0 0 0", rf_we, rf_rd, rf_wd); end
    checks++; if (clear_busy !== 1'b0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_state got busy=%b stall=%0d exp 0 0", clear_busy, stall_cnt); end
    reset = 0; idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_single_write;
    a_valid = 1; a_rd = 5'd5; a_wd = 32'h55555555;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL single_ready got a=%b b=%b exp 1 0", a_ready, b_ready); end
    @(negedge clk);
    a_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'h55555555) begin errors++; $display("FAIL single_port got we=%b rd=%0d wd=%h exp 1 5 55555555", rf_we, rf_rd, rf_wd); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_drop got %b exp 0", rf_we); end
    checks++; if (rf_read(5) !== 32'h55555555) begin errors++; $display("FAIL single_x5 got %h exp 55555555", rf_read(5)); end
  endtask

  task automatic test_round_robin;
    reset = 1; idle_inputs();
    @(negedge clk);
    reset = 0;
    a_valid = 1; a_rd = 5'd3; a_wd = 32'h33333333;
    b_valid = 1; b_rd = 5'd4; b_wd = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin errors++; $display("FAIL rr_grant%0d got a=%b b=%b exp a=%b", i, a_ready, b_ready, i % 2 == 0); end
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_rd !== (i % 2 == 0 ? 5'd3 : 5'd4)) begin errors++; $display("FAIL rr_port%0d got we=%b rd=%0d exp 1 %0d", i, rf_we, rf_rd, i % 2 == 0 ? 3 : 4); end
    end
    idle_inputs();
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL rr_stall got %0d exp 4", stall_cnt); end
    @(negedge clk);
    checks++; if (rf_read(3) !== 32'h33333333 || rf_read(4) !== 32'h44444444) begin errors++; $display("FAIL rr_regs got x3=%h x4=%h exp 33333333 44444444", rf_read(3), rf_read(4)); end
  endtask

  task automatic test_x0_write;
    a_valid = 1; a_rd = 5'd0; a_wd = 32'hDEADBEEF;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", a_ready); end
    @(negedge clk);
    a_valid = 0;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b exp 0", rf_we); end
    checks++; if (rf_read(0) !== 32'd0) begin errors++; $display("FAIL x0_read got %h exp 0", rf_read(0)); end
    a_valid = 1; a_rd = 5'd6; a_wd = 32'h66666666;
    b_valid = 1; b_rd = 5'd4; b_wd = 32'h44444444;
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin errors++; $display("FAIL x0_last got a=%b b=%b exp 0 1", a_ready, b_ready); end
    @(negedge clk);
    idle_inputs();
    checks++; if (stall_cnt !== 16'd5 || rf_rd !== 5'd4 || rf_we !== 1'b1) begin errors++; $display("FAIL x0_after got stall=%0d rd=%0d we=%b exp 5 4 1", stall_cnt, rf_rd, rf_we); end
    @(negedge clk);
  endtask

  task automatic preload;
    for (int j = 1; j < 32; j++) begin
      a_valid = 1; a_rd = 5'(j); a_wd = 32'(j) * 32'h11111111;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL preload_ready%0d got %b exp 1", j, a_ready); end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_clear;
    logic [31:0] exp;
    preload();
    checks++; if (rf_read(31) !== 32'h1111110F) begin errors++; $display("FAIL preload_x31 got %h exp 1111110f", rf_read(31)); end
    clear_req = 1; a_valid = 1; a_rd = 5'd7; a_wd = 32'h77AA77AA;
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL clear_entry_ready got a=%b b=%b exp 0 0", a_ready, b_ready); end
    @(negedge clk);
    clear_req = 0;
    for (int i = 1; i < 32; i++) begin
      checks++; if (clear_busy !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'(i) || rf_wd !== 32'd0 || a_ready !== 1'b0) begin
        errors++; $display("FAIL clear_step%0d got busy=%b we=%b rd=%0d wd=%h a_ready=%b exp 1 1 %0d 0 0", i, clear_busy, rf_we, rf_rd, rf_wd, a_ready, i);
      end
      if (i == 5) clear_req = 1;
      if (i == 6) clear_req = 0;
      @(negedge clk);
    end
    checks++; if (clear_busy !== 1'b0 || rf_we !== 1'b0 || a_ready !== 1'b1) begin errors++; $display("FAIL clear_end got busy=%b we=%b a_ready=%b exp 0 0 1", clear_busy, rf_we, a_ready); end
    @(negedge clk);
    idle_inputs();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wd !== 32'h77AA77AA) begin errors++; $display("FAIL clear_a_port got we=%b rd=%0d wd=%h exp 1 7 77aa77aa", rf_we, rf_rd, rf_wd); end
    @(negedge clk);
    for (int j = 1; j < 32; j++) begin
      exp = j == 7 ? 32'h77AA77AA : 32'd0;
      checks++; if (rf_read(j) !== exp) begin errors++; $display("FAIL clear_x%0d got %h exp %h", j, rf_read(j), exp); end
    end
    checks++; if (stall_cnt !== 16'd5 || clear_busy !== 1'b0) begin errors++; $display("FAIL clear_stall got stall=%0d busy=%b exp 5 0", stall_cnt, clear_busy); end
  endtask

  task automatic test_reset_mid_clear;
    logic [31:0] exp;
    preload();
    clear_req = 1;
    @(negedge clk);
    clear_req = 0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    checks++; if (rf_rd !== 5'd10 || clear_busy !== 1'b1) begin errors++; $display("FAIL midclr_pos got rd=%0d busy=%b exp 10 1", rf_rd, clear_busy); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++; if (clear_busy !== 1'b0 || rf_we !== 1'b0 || rf_rd !== 5'd0) begin errors++; $display("FAIL midclr_reset got busy=%b we=%b rd=%0d exp 0 0 0", clear_busy, rf_we, rf_rd); end
    @(negedge clk);
    for (int j = 1; j < 32; j++) begin
      exp = j < 10 ? 32'd0 : 32'(j) * 32'h11111111;
      checks++; if (rf_read(j) !== exp) begin errors++; $display("FAIL midclr_x%0d got %h exp %h", j, rf_read(j), exp); end
    end
  endtask

  task automatic test_clear_priority;
    int waited;
    clear_req = 1;
    a_valid = 1; a_rd = 5'd12; a_wd = 32'hC0C0C0C0;
    b_valid = 1; b_rd = 5'd13; b_wd = 32'hB0B0B0B0;
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got a=%b b=%b exp 0 0", a_ready, b_ready); end
    @(negedge clk);
    clear_req = 0;
    checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL prio_busy got %b exp 1", clear_busy); end
    waited = 0;
    while (clear_busy === 1'b1 && waited < 40) begin
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL prio_during got a=%b b=%b exp 0 0", a_ready, b_ready); end
      @(negedge clk);
      waited++;
    end
    checks++; if (waited != 31) begin errors++; $display("FAIL prio_busy_len got %0d exp 31", waited); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL prio_stall got %0d exp 0", stall_cnt); end
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL prio_after got a=%b b=%b exp 1 0", a_ready, b_ready); end
    @(negedge clk);
    a_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd12 || rf_wd !== 32'hC0C0C0C0 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL prio_a_port got we=%b rd=%0d wd=%h stall=%0d exp 1 12 c0c0c0c0 1", rf_we, rf_rd, rf_wd, stall_cnt);
    end
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL prio_b_ready got %b exp 1", b_ready); end
    @(negedge clk);
    idle_inputs();
    checks++; if (rf_rd !== 5'd13 || rf_wd !== 32'hB0B0B0B0 || stall_cnt !== 16'd1) begin errors++; $display("FAIL prio_b_port got rd=%0d wd=%h stall=%0d exp 13 b0b0b0b0 1", rf_rd, rf_wd, stall_cnt); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1; idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_write();
    test_round_robin();
    test_x0_write();
    test_clear();
    test_reset_mid_clear();
    test_clear_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
